stopwatch_counter: RTL and testbench

- Consumes the single-cycle `pulse10Hz` strobe from the pulse generator.
- Keeps a run/pause/clear stopwatch count in BCD: minutes, tens of seconds, seconds, tenths; range 0:00.0 to 9:59.9.
- Sits between the pulse generator and the display multiplexer/decoder stage. Outputs are registered BCD digits plus status flags.

---
 rtl/stopwatch_counter.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// Run/pause/clear BCD stopwatch (0:00.0 .. 9:59.9) advanced by a 10 Hz strobe.
// Optional lap display freeze is compiled in with `define STOPWATCH_LAP_HOLD_EN.
module stopwatch_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic       pulse10Hz,
  input  logic       startStop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] tenths,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FULL} state_t;

  state_t     state_reg;
  logic [3:0] t_reg, so_reg, st_reg, mo_reg;
  logic [3:0] t_inc, so_inc, st_inc, mo_inc;
  logic [3:0] t_next, so_next, st_next, mo_next;
  logic       terminal, saturate, count_advance, count_zero;

  // Ripple BCD increment; at 9:59.9 every digit rolls to zero.
  always_comb begin
    t_inc  = t_reg;
    so_inc = so_reg;
    st_inc = st_reg;
    mo_inc = mo_reg;
    if (t_reg != 4'd9) begin
      t_inc = t_reg + 4'd1;
    end else begin
      t_inc = 4'd0;
      if (so_reg != 4'd9) begin
        so_inc = so_reg + 4'd1;
      end else begin
        so_inc = 4'd0;
        if (st_reg != 4'd5) begin
          st_inc = st_reg + 4'd1;
        end else begin
          st_inc = 4'd0;
          mo_inc = (mo_reg != 4'd9) ? mo_reg + 4'd1 : 4'd0;
        end
      end
    end
  end

  always_comb begin
    terminal      = (t_reg == 4'd9) && (so_reg == 4'd9) && (st_reg == 4'd5) && (mo_reg == 4'd9);
    saturate      = (state_reg == RUNNING) && pulse10Hz && terminal && !WRAP;
    count_advance = (state_reg == RUNNING) && pulse10Hz && !saturate;
    count_zero    = ((state_reg == PAUSED) || (state_reg == FULL)) && clear;
    t_next  = t_reg;
    so_next = so_reg;
    st_next = st_reg;
    mo_next = mo_reg;
    if (count_zero) begin
      t_next  = 4'd0;
      so_next = 4'd0;
      st_next = 4'd0;
      mo_next = 4'd0;
    end else if (count_advance) begin
      t_next  = t_inc;
      so_next = so_inc;
      st_next = st_inc;
      mo_next = mo_inc;
    end
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_reg <= IDLE;
      t_reg     <= 4'd0;
      so_reg    <= 4'd0;
      st_reg    <= 4'd0;
      mo_reg    <= 4'd0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      t_reg    <= t_next;
      so_reg   <= so_next;
      st_reg   <= st_next;
      mo_reg   <= mo_next;
      overflow <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (startStop) begin
            state_reg <= RUNNING;
            running   <= 1'b1;
          end
        end
        RUNNING: begin
          if (saturate) begin
            state_reg <= FULL;
            running   <= 1'b0;
            overflow  <= 1'b1;
          end else begin
            // Wrap pulse is issued even when a pause lands on the same strobe.
            if (pulse10Hz && terminal) overflow <= 1'b1;
            if (startStop) begin
              state_reg <= PAUSED;
              running   <= 1'b0;
            end
          end
        end
        PAUSED: begin
          if (clear) begin
            state_reg <= IDLE;
          end else if (startStop) begin
            state_reg <= RUNNING;
            running   <= 1'b1;
          end
        end
        FULL: begin
          if (clear) state_reg <= IDLE;
          else       overflow  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          running   <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       frozen_reg, frozen_next, leave_running;
  logic [3:0] disp_t_reg, disp_so_reg, disp_st_reg, disp_mo_reg;

  always_comb begin
    leave_running = (state_reg == RUNNING) && (startStop || saturate);
    frozen_next   = 1'b0;
    if ((state_reg == RUNNING) && !leave_running) frozen_next = frozen_reg ^ lap;
  end

  // Display registers: snapshot on freeze, hold while frozen, else track the live count.
  always_ff @(posedge clk5) begin
    if (reset) begin
      frozen_reg  <= 1'b0;
      disp_t_reg  <= 4'd0;
      disp_so_reg <= 4'd0;
      disp_st_reg <= 4'd0;
      disp_mo_reg <= 4'd0;
    end else begin
      frozen_reg <= frozen_next;
      if (frozen_next && !frozen_reg) begin
        disp_t_reg  <= t_reg;
        disp_so_reg <= so_reg;
        disp_st_reg <= st_reg;
        disp_mo_reg <= mo_reg;
      end else if (!frozen_next) begin
        disp_t_reg  <= t_next;
        disp_so_reg <= so_next;
        disp_st_reg <= st_next;
        disp_mo_reg <= mo_next;
      end
    end
  end

  assign tenths  = disp_t_reg;
  assign secOnes = disp_so_reg;
  assign secTens = disp_st_reg;
  assign minOnes = disp_mo_reg;
`else
  assign tenths  = t_reg;
  assign secOnes = so_reg;
  assign secTens = st_reg;
  assign minOnes = mo_reg;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: a wrapping and a saturating stopwatch driven by the same stimulus.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  logic clk5 = 1'b0;
  logic reset = 1'b1;
  logic pulse10Hz = 1'b0;
  logic startStop = 1'b0;
  logic clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap = 1'b0;
`endif
  logic [3:0] w_t, w_so, w_st, w_mo, s_t, s_so, s_st, s_mo;
  logic       w_run, w_ovf, s_run, s_ovf;
  logic [15:0] w_dig, s_dig;
  int checks = 0;
  int errors = 0;

  always #100 clk5 = ~clk5;

  assign w_dig = {w_mo, w_st, w_so, w_t};
  assign s_dig = {s_mo, s_st, s_so, s_t};

  stopwatch_counter #(.WRAP(1'b1)) dut_wrap (
    .clk5(clk5), .reset(reset), .pulse10Hz(pulse10Hz), .startStop(startStop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .tenths(w_t), .secOnes(w_so), .secTens(w_st), .minOnes(w_mo),
    .running(w_run), .overflow(w_ovf)
  );

  stopwatch_counter #(.WRAP(1'b0)) dut_sat (
    .clk5(clk5), .reset(reset), .pulse10Hz(pulse10Hz), .startStop(startStop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .tenths(s_t), .secOnes(s_so), .secTens(s_st), .minOnes(s_mo),
    .running(s_run), .overflow(s_ovf)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge that consumed them.
  task automatic step(input logic p, input logic ss, input logic cl, input logic rs);
    pulse10Hz = p;
    startStop = ss;
    clear     = cl;
    reset     = rs;
    @(posedge clk5);
    #1;
    pulse10Hz = 1'b0;
    startStop = 1'b0;
    clear     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_w_dig", w_dig, 16'h0000);
    chk("rst_s_dig", s_dig, 16'h0000);
    chk("rst_run", {14'd0, w_run, s_run}, 16'h0000);
    chk("rst_ovf", {14'd0, w_ovf, s_ovf}, 16'h0000);

    // Start and 15 strobes -> 0:01.5
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(15);
    chk("run15_dig", w_dig, 16'h0015);
    chk("run15_run", {15'd0, w_run}, 16'h0001);
    $display("step run15: digits %h running %b", w_dig, w_run);

    // 599 strobes, pause, pause ignores strobe, clear -> IDLE
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(599);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_dig", w_dig, 16'h0599);
    chk("pause_run", {15'd0, w_run}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause_hold", w_dig, 16'h0599);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_dig", w_dig, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_nocount", w_dig, 16'h0000);
    chk("idle_run", {15'd0, w_run}, 16'h0000);
    $display("step pause/clear: digits %h running %b", w_dig, w_run);

    // Simultaneous events
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("run_p_ss_dig", w_dig, 16'h0004);
    chk("run_p_ss_run", {15'd0, w_run}, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pau_p_ss_dig", w_dig, 16'h0004);
    chk("pau_p_ss_run", {15'd0, w_run}, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_ss_dig", w_dig, 16'h0000);
    chk("clr_ss_run", {15'd0, w_run}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_ss_idle", w_dig, 16'h0000);
    $display("step simultaneous: digits %h running %b", w_dig, w_run);

    // Reset mid-count at 3:27.4
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(2074);
    chk("at_3274", w_dig, 16'h3274);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_dig", w_dig, 16'h0000);
    chk("midrst_flags", {14'd0, w_run, w_ovf}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_idle", w_dig, 16'h0000);
    $display("step midreset: digits %h running %b overflow %b", w_dig, w_run, w_ovf);

    // Terminal count: wrap vs saturate
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(5999);
    chk("top_w_dig", w_dig, 16'h9599);
    chk("top_s_dig", s_dig, 16'h9599);
    chk("top_ovf", {14'd0, w_ovf, s_ovf}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_dig", w_dig, 16'h0000);
    chk("wrap_flags", {14'd0, w_run, w_ovf}, 16'h0003);
    chk("sat_dig", s_dig, 16'h9599);
    chk("sat_flags", {14'd0, s_run, s_ovf}, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ovf_1cyc", {15'd0, w_ovf}, 16'h0000);
    chk("sat_ovf_held", {15'd0, s_ovf}, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_ss_ign", {s_dig[15:2], s_run, s_ovf}, {14'h2566, 2'b01});
    chk("wrap_ss_pause", {15'd0, w_run}, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_clr_dig", s_dig, 16'h0000);
    chk("full_clr_flags", {14'd0, s_run, s_ovf}, 16'h0000);
    $display("step terminal: wrap %h/%b%b sat %h/%b%b", w_dig, w_run, w_ovf, s_dig, s_run, s_ovf);

    // Terminal count together with startStop
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(5999);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tss_w_dig", w_dig, 16'h0000);
    chk("tss_w_flags", {14'd0, w_run, w_ovf}, 16'h0001);
    chk("tss_s_dig", s_dig, 16'h9599);
    chk("tss_s_flags", {14'd0, s_run, s_ovf}, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("tss_w_resume", {14'd0, w_run, w_ovf}, 16'h0002);
    chk("tss_s_full", {14'd0, s_run, s_ovf}, 16'h0001);
    $display("step terminal+ss: wrap %h/%b%b sat %h/%b%b", w_dig, w_run, w_ovf, s_dig, s_run, s_ovf);

`ifdef STOPWATCH_LAP_HOLD_EN
    // Lap freeze and release
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(20);
    chk("lap_pre", w_dig, 16'h0020);
    lap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    lap = 1'b0;
    pulses(10);
    chk("lap_hold", w_dig, 16'h0020);
    chk("lap_hold_run", {15'd0, w_run}, 16'h0001);
    lap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    lap = 1'b0;
    chk("lap_release", w_dig, 16'h0030);
    lap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    lap = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lap_hold2", w_dig, 16'h0030);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_leave", w_dig, 16'h0031);
    $display("step lap: digits %h running %b", w_dig, w_run);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
